// File: rtl/sprite_frame_ram.sv
// Double-buffered sprite pixel store: the display reads the front bank while the writer fills the back bank.
// The optional back-bank clear sequencer is compiled in with `define SPRITE_RAM_CLEAR_EN.
module sprite_frame_ram #(
   parameter int                DATA_W       = 12,
   parameter int                ADDR_W       = 8,
   parameter int                READ_LATENCY = 1,
   parameter logic [DATA_W-1:0] INIT_COLOR   = 12'h247
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_dropped,
   input  logic              swap_req,
   input  logic              vsync,
   output logic              swap_pending,
   output logic              front_bank,
`ifdef SPRITE_RAM_CLEAR_EN
   input  logic              clear_req,
   input  logic [DATA_W-1:0] clear_value,
`endif
   output logic              busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   // Words are stored XOR INIT_COLOR, so the all-zero power-up state of the array reads back as INIT_COLOR.
   logic [DATA_W-1:0] mem [0:2*DEPTH-1];

   typedef enum logic {IDLE, PENDING} swap_state_t;
   swap_state_t state_reg;

   logic              write_ok;
   logic              mem_we;
   logic [ADDR_W:0]   mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [ADDR_W:0]   mem_raddr;
   logic [DATA_W-1:0] mem_rword;

   assign write_ok  = wr_en & ~swap_pending & ~busy;
   assign mem_raddr = {front_bank, rd_addr};
   assign mem_rword = mem[mem_raddr] ^ INIT_COLOR;

`ifdef SPRITE_RAM_CLEAR_EN
   logic              busy_reg;
   logic [ADDR_W-1:0] clr_cnt_reg;
   logic [DATA_W-1:0] clr_val_reg;

   // Front bank cannot move while busy: swap requests are refused, so the whole clear lands in one bank.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy_reg    <= 1'b0;
         clr_cnt_reg <= '0;
         clr_val_reg <= '0;
      end else if (busy_reg) begin
         clr_cnt_reg <= clr_cnt_reg + 1'b1;
         if (clr_cnt_reg == {ADDR_W{1'b1}})
            busy_reg <= 1'b0;
      end else if (clear_req && !swap_pending) begin
         busy_reg    <= 1'b1;
         clr_cnt_reg <= '0;
         clr_val_reg <= clear_value;
      end
   end

   assign busy = busy_reg;
`else
   assign busy = 1'b0;
`endif

   always_comb begin
      mem_we    = write_ok;
      mem_waddr = {~front_bank, wr_addr};
      mem_wdata = wr_data;
`ifdef SPRITE_RAM_CLEAR_EN
      if (busy_reg) begin
         mem_we    = 1'b1;
         mem_waddr = {~front_bank, clr_cnt_reg};
         mem_wdata = clr_val_reg;
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (mem_we)
         mem[mem_waddr] <= mem_wdata ^ INIT_COLOR;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         wr_dropped <= 1'b0;
      else
         wr_dropped <= wr_en & (swap_pending | busy);
   end

   // A simultaneous swap_req and vsync swaps at once without ever showing a pending state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         swap_pending <= 1'b0;
         front_bank   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (swap_req && !busy) begin
                  if (vsync) begin
                     front_bank <= ~front_bank;
                  end else begin
                     state_reg    <= PENDING;
                     swap_pending <= 1'b1;
                  end
               end
            end
            PENDING: begin
               if (vsync) begin
                  state_reg    <= IDLE;
                  swap_pending <= 1'b0;
                  front_bank   <= ~front_bank;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   generate
      if (READ_LATENCY == 1) begin : g_lat1
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               rd_data  <= '0;
               rd_valid <= 1'b0;
            end else begin
               rd_valid <= rd_en;
               if (rd_en)
                  rd_data <= mem_rword;
            end
         end
      end else begin : g_lat2
         logic [DATA_W-1:0] stage_data_reg;
         logic              stage_valid_reg;

         // The bank bit is captured with the address here, so a swap cannot redirect an in-flight read.
         always_ff @(posedge clock) begin
            if (rd_en)
               stage_data_reg <= mem_rword;
         end

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               stage_valid_reg <= 1'b0;
               rd_valid        <= 1'b0;
               rd_data         <= '0;
            end else begin
               stage_valid_reg <= rd_en;
               rd_valid        <= stage_valid_reg;
               if (stage_valid_reg)
                  rd_data <= stage_data_reg;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_sprite_frame_ram.sv
// Directed bench for sprite_frame_ram: a latency-1 and a latency-2 instance share all stimulus.
// Define SPRITE_RAM_CLEAR_EN to also exercise the clear sequencer.
module tb_sprite_frame_ram;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        rd_en;
   logic [7:0]  rd_addr;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [11:0] wr_data;
   logic        swap_req;
   logic        vsync;
`ifdef SPRITE_RAM_CLEAR_EN
   logic        clear_req;
   logic [11:0] clear_value;
`endif

   logic [11:0] rd_data, rd_data_l2;
   logic        rd_valid, rd_valid_l2;
   logic        wr_dropped, wr_dropped_l2;
   logic        swap_pending, swap_pending_l2;
   logic        front_bank, front_bank_l2;
   logic        busy, busy_l2;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   sprite_frame_ram #(.DATA_W(12), .ADDR_W(8), .READ_LATENCY(1), .INIT_COLOR(12'h247)) u_lat1 (
      .clock(clock), .reset_n(reset_n),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_dropped(wr_dropped),
      .swap_req(swap_req), .vsync(vsync), .swap_pending(swap_pending), .front_bank(front_bank),
`ifdef SPRITE_RAM_CLEAR_EN
      .clear_req(clear_req), .clear_value(clear_value),
`endif
      .busy(busy)
   );

   sprite_frame_ram #(.DATA_W(12), .ADDR_W(8), .READ_LATENCY(2), .INIT_COLOR(12'h247)) u_lat2 (
      .clock(clock), .reset_n(reset_n),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_l2), .rd_valid(rd_valid_l2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_dropped(wr_dropped_l2),
      .swap_req(swap_req), .vsync(vsync), .swap_pending(swap_pending_l2), .front_bank(front_bank_l2),
`ifdef SPRITE_RAM_CLEAR_EN
      .clear_req(clear_req), .clear_value(clear_value),
`endif
      .busy(busy_l2)
   );

   task automatic test_reset();
      reset_n  = 1'b0;
      rd_en    = 1'b0; rd_addr = '0;
      wr_en    = 1'b0; wr_addr = '0; wr_data = '0;
      swap_req = 1'b0; vsync   = 1'b0;
`ifdef SPRITE_RAM_CLEAR_EN
      clear_req = 1'b0; clear_value = '0;
`endif
      repeat (2) @(negedge clock);
      checks++;
      if ({rd_valid, wr_dropped, swap_pending, front_bank, busy} !== 5'b0) begin
         failures++;
         $display("FAIL reset_flags_l1 got=%b expected=00000", {rd_valid, wr_dropped, swap_pending, front_bank, busy});
      end
      checks++;
      if ({rd_valid_l2, wr_dropped_l2, swap_pending_l2, front_bank_l2, busy_l2} !== 5'b0) begin
         failures++;
         $display("FAIL reset_flags_l2 got=%b expected=00000", {rd_valid_l2, wr_dropped_l2, swap_pending_l2, front_bank_l2, busy_l2});
      end
      checks++;
      if ({rd_data, rd_data_l2} !== 24'h0) begin
         failures++;
         $display("FAIL reset_rd_data got=%h expected=000000", {rd_data, rd_data_l2});
      end
      reset_n = 1'b1;
      @(negedge clock);
      $display("reset released");
   endtask

   task automatic test_init_read();
      rd_en = 1'b1; rd_addr = 8'd0;
      @(negedge clock);
      rd_addr = 8'd255;
      checks++;
      if ({rd_valid, rd_data, front_bank, rd_valid_l2} !== {1'b1, 12'h247, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL init_read0 got v=%b d=%h fb=%b v2=%b expected v=1 d=247 fb=0 v2=0", rd_valid, rd_data, front_bank, rd_valid_l2);
      end
      @(negedge clock);
      rd_en = 1'b0;
      checks++;
      if ({rd_valid_l2, rd_data_l2} !== {1'b1, 12'h247}) begin
         failures++;
         $display("FAIL init_read0_l2 got v=%b d=%h expected v=1 d=247", rd_valid_l2, rd_data_l2);
      end
      @(negedge clock);
      checks++;
      if ({rd_valid, rd_data} !== {1'b0, 12'h247}) begin
         failures++;
         $display("FAIL init_read255_hold got v=%b d=%h expected v=0 d=247", rd_valid, rd_data);
      end
      $display("read addr=00,ff data=%h", rd_data);
   endtask

   task automatic test_swap();
      wr_en = 1'b1; wr_addr = 8'd5; wr_data = 12'h888;
      @(negedge clock);
      wr_addr = 8'd255; wr_data = 12'habc;
      checks++;
      if (wr_dropped !== 1'b0) begin
         failures++;
         $display("FAIL swap_wr_not_dropped got=%b expected=0", wr_dropped);
      end
      @(negedge clock);
      wr_en = 1'b0;
      rd_en = 1'b1; rd_addr = 8'd5;
      @(negedge clock);
      rd_en = 1'b0;
      checks++;
      if (rd_data !== 12'h247) begin
         failures++;
         $display("FAIL swap_front_isolated got=%h expected=247", rd_data);
      end
      swap_req = 1'b1;
      @(negedge clock);
      swap_req = 1'b0;
      checks++;
      if ({swap_pending, front_bank} !== 2'b10) begin
         failures++;
         $display("FAIL swap_pending_set got=%b expected=10", {swap_pending, front_bank});
      end
      repeat (2) @(negedge clock);
      vsync = 1'b1;
      @(negedge clock);
      vsync = 1'b0;
      checks++;
      if ({swap_pending, front_bank} !== 2'b01) begin
         failures++;
         $display("FAIL swap_on_vsync got=%b expected=01", {swap_pending, front_bank});
      end
      rd_en = 1'b1; rd_addr = 8'd5;
      @(negedge clock);
      rd_addr = 8'd255;
      checks++;
      if (rd_data !== 12'h888) begin
         failures++;
         $display("FAIL swap_read5 got=%h expected=888", rd_data);
      end
      @(negedge clock);
      rd_en = 1'b0;
      checks++;
      if (rd_data !== 12'habc) begin
         failures++;
         $display("FAIL swap_read255 got=%h expected=abc", rd_data);
      end
      $display("swap done front=%b", front_bank);
   endtask

   task automatic test_pending_drop();
      swap_req = 1'b1;
      @(negedge clock);
      swap_req = 1'b0;
      repeat (100) @(negedge clock);
      checks++;
      if ({swap_pending, front_bank} !== 2'b11) begin
         failures++;
         $display("FAIL pending_hold got=%b expected=11", {swap_pending, front_bank});
      end
      wr_en = 1'b1; wr_addr = 8'd9; wr_data = 12'h123;
      @(negedge clock);
      wr_en = 1'b0;
      checks++;
      if (wr_dropped !== 1'b1) begin
         failures++;
         $display("FAIL drop_pulse got=%b expected=1", wr_dropped);
      end
      @(negedge clock);
      checks++;
      if (wr_dropped !== 1'b0) begin
         failures++;
         $display("FAIL drop_pulse_end got=%b expected=0", wr_dropped);
      end
      vsync = 1'b1;
      @(negedge clock);
      vsync = 1'b0;
      checks++;
      if ({swap_pending, front_bank} !== 2'b00) begin
         failures++;
         $display("FAIL pending_release got=%b expected=00", {swap_pending, front_bank});
      end
      rd_en = 1'b1; rd_addr = 8'd9;
      @(negedge clock);
      rd_addr = 8'd5;
      checks++;
      if (rd_data !== 12'h247) begin
         failures++;
         $display("FAIL dropped_word9 got=%h expected=247", rd_data);
      end
      @(negedge clock);
      rd_en = 1'b0;
      checks++;
      if (rd_data !== 12'h247) begin
         failures++;
         $display("FAIL bank0_word5 got=%h expected=247", rd_data);
      end
      $display("write addr=09 dropped, front=%b", front_bank);
   endtask

   task automatic test_same_cycle();
      swap_req = 1'b1; vsync = 1'b1;
      @(negedge clock);
      swap_req = 1'b0; vsync = 1'b0;
      checks++;
      if ({swap_pending, front_bank} !== 2'b01) begin
         failures++;
         $display("FAIL same_cycle_swap got=%b expected=01", {swap_pending, front_bank});
      end
      @(negedge clock);
      checks++;
      if ({swap_pending, front_bank} !== 2'b01) begin
         failures++;
         $display("FAIL same_cycle_settle got=%b expected=01", {swap_pending, front_bank});
      end
      $display("same-cycle swap front=%b", front_bank);
   endtask

   task automatic test_latency2();
      wr_en = 1'b1; wr_addr = 8'd7; wr_data = 12'h777;
      @(negedge clock);
      wr_en = 1'b0;
      swap_req = 1'b1;
      @(negedge clock);
      swap_req = 1'b0;
      rd_en = 1'b1; rd_addr = 8'd7;
      @(negedge clock);
      vsync = 1'b1;
      checks++;
      if (rd_data !== 12'h247) begin
         failures++;
         $display("FAIL lat1_first got=%h expected=247", rd_data);
      end
      @(negedge clock);
      vsync = 1'b0;
      checks++;
      if ({rd_data, rd_valid_l2, rd_data_l2} !== {12'h247, 1'b1, 12'h247}) begin
         failures++;
         $display("FAIL lat_second got l1=%h v2=%b l2=%h expected l1=247 v2=1 l2=247", rd_data, rd_valid_l2, rd_data_l2);
      end
      @(negedge clock);
      rd_en = 1'b0;
      checks++;
      if ({rd_data, front_bank_l2, rd_data_l2} !== {12'h777, 1'b0, 12'h247}) begin
         failures++;
         $display("FAIL lat_third got l1=%h fb2=%b l2=%h expected l1=777 fb2=0 l2=247", rd_data, front_bank_l2, rd_data_l2);
      end
      @(negedge clock);
      checks++;
      if ({rd_valid, rd_valid_l2, rd_data_l2} !== {1'b0, 1'b1, 12'h777}) begin
         failures++;
         $display("FAIL lat2_new_bank got v1=%b v2=%b l2=%h expected v1=0 v2=1 l2=777", rd_valid, rd_valid_l2, rd_data_l2);
      end
      @(negedge clock);
      checks++;
      if ({rd_valid_l2, rd_data_l2} !== {1'b0, 12'h777}) begin
         failures++;
         $display("FAIL lat2_hold got v=%b d=%h expected v=0 d=777", rd_valid_l2, rd_data_l2);
      end
      $display("latency-2 reads across swap complete");
   endtask

`ifdef SPRITE_RAM_CLEAR_EN
   task automatic test_clear();
      int busy_cycles;
      clear_value = 12'h888; clear_req = 1'b1;
      @(negedge clock);
      clear_req = 1'b0;
      busy_cycles = (busy === 1'b1) ? 1 : 0;
      for (int i = 0; i < 300 && busy === 1'b1; i++) begin
         @(negedge clock);
         if (busy === 1'b1) busy_cycles++;
      end
      checks++;
      if (busy_cycles != 256) begin
         failures++;
         $display("FAIL clear_busy_cycles got=%0d expected=256", busy_cycles);
      end
      swap_req = 1'b1; vsync = 1'b1;
      @(negedge clock);
      swap_req = 1'b0; vsync = 1'b0;
      rd_en = 1'b1; rd_addr = 8'd0;
      @(negedge clock);
      rd_addr = 8'd100;
      checks++;
      if (rd_data !== 12'h888) begin
         failures++;
         $display("FAIL clear_word0 got=%h expected=888", rd_data);
      end
      @(negedge clock);
      rd_addr = 8'd255;
      checks++;
      if (rd_data !== 12'h888) begin
         failures++;
         $display("FAIL clear_word100 got=%h expected=888", rd_data);
      end
      @(negedge clock);
      rd_en = 1'b0;
      checks++;
      if (rd_data !== 12'h888) begin
         failures++;
         $display("FAIL clear_word255 got=%h expected=888", rd_data);
      end
      clear_value = 12'h5a5; clear_req = 1'b1;
      @(negedge clock);
      clear_req = 1'b0;
      repeat (100) @(negedge clock);
      reset_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL clear_abort got=%b expected=0", busy);
      end
      @(negedge clock);
      reset_n = 1'b1;
      rd_en = 1'b1; rd_addr = 8'd99;
      @(negedge clock);
      rd_addr = 8'd100;
      checks++;
      if ({busy, front_bank, rd_data} !== {1'b0, 1'b0, 12'h5a5}) begin
         failures++;
         $display("FAIL partial_word99 got busy=%b fb=%b d=%h expected busy=0 fb=0 d=5a5", busy, front_bank, rd_data);
      end
      @(negedge clock);
      rd_en = 1'b0;
      checks++;
      if (rd_data !== 12'h247) begin
         failures++;
         $display("FAIL partial_word100 got=%h expected=247", rd_data);
      end
      $display("clear and aborted clear complete");
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_init_read();
      test_swap();
      test_pending_drop();
      test_same_cycle();
      test_latency2();
`ifdef SPRITE_RAM_CLEAR_EN
      test_clear();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
